// File: rtl/vec_itr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vec_itr_ctrl
// Brief    : Vectored priority interrupt controller with edge/level sources,
//            enable mask and nested servicing for the stage-0 PC mux.
// Revision : 1.0
// ============================================================================
module vec_itr_ctrl #(
    parameter int               N_SRC      = 4,
    parameter int               VEC_W      = 8,
    parameter logic [VEC_W-1:0] VEC_BASE   = 8'hF0,
    parameter int               VEC_STRIDE = 2,
    parameter int               NEST_DEPTH = 2
) (
    input  logic             g_clk,
    input  logic             g_clr,
    input  logic [N_SRC-1:0] itr_in,
    input  logic             itr_en,
    input  logic             mask_wr,
    input  logic [N_SRC-1:0] mask_in,
    input  logic             mode_wr,
    input  logic [N_SRC-1:0] mode_in,
    input  logic             itr_ack,
    input  logic             itr_ret,
    output logic             i_pending,
    output logic [VEC_W-1:0] itr_pc_addr,
    output logic [3:0]       itr_id,
    output logic [3:0]       active_id,
    output logic [N_SRC-1:0] itr_reg,
    output logic [N_SRC-1:0] mask_reg,
    output logic [3:0]       depth,
    output logic             nest_err
);

    localparam logic [3:0] c_idle      = 4'(N_SRC);
    localparam logic [3:0] c_max_depth = 4'(NEST_DEPTH);

    logic [N_SRC-1:0] r_in_q;
    logic [N_SRC-1:0] r_pend;
    logic [N_SRC-1:0] r_mask;
    logic [N_SRC-1:0] r_mode;
    logic [3:0]       r_active_id;
    logic [3:0]       r_depth;
    logic [3:0]       r_stack [0:7];
    logic             r_pending;
    logic [3:0]       r_itr_id;
    logic [VEC_W-1:0] r_pc;
    logic             r_nest_err;

    logic [N_SRC-1:0] w_pend_nxt;
    logic [N_SRC-1:0] w_on_stack;
    logic             w_cand_vld;
    logic [3:0]       w_cand;
    logic [VEC_W-1:0] w_vec;
    logic             w_room;
    logic             w_ack;
    logic [2:0]       w_top;
    logic [2:0]       w_below;

    assign w_ack   = itr_ack & r_pending & ~itr_ret;
    assign w_top   = r_depth[2:0];
    assign w_below = r_depth[2:0] - 3'd1;
    assign w_room  = itr_en && (r_depth < c_max_depth);

    // Entry 0 only ever holds the idle marker, so it never shadows a source.
    always_comb begin
        w_on_stack = '0;
        for (int i = 0; i < N_SRC; i++) begin
            for (int j = 1; j < 8; j++) begin
                if ((4'(j) < r_depth) && (r_stack[3'(j)] == 4'(i))) begin
                    w_on_stack[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_cand_vld = 1'b0;
        w_cand     = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_room && r_pend[i] && r_mask[i] && !w_on_stack[i] &&
                ((r_depth == 4'd0) || (4'(i) < r_active_id))) begin
                w_cand_vld = 1'b1;
                w_cand     = 4'(i);
            end
        end
    end

    assign w_vec = VEC_BASE + VEC_W'(w_cand) * VEC_W'(VEC_STRIDE);

    always_comb begin
        w_pend_nxt = r_pend;
        for (int i = 0; i < N_SRC; i++) begin
            if (r_mode[i]) begin
                if (w_ack && (r_itr_id == 4'(i))) begin
                    w_pend_nxt[i] = 1'b0;
                end
                if (itr_in[i] && !r_in_q[i]) begin
                    w_pend_nxt[i] = 1'b1;
                end
            end else if (mode_wr && mode_in[i]) begin
                w_pend_nxt[i] = 1'b0;
            end else begin
                w_pend_nxt[i] = itr_in[i];
            end
        end
    end

    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            r_in_q      <= '0;
            r_pend      <= '0;
            r_mask      <= '0;
            r_mode      <= '1;
            r_active_id <= c_idle;
            r_depth     <= '0;
            for (int k = 0; k < 8; k++) begin
                r_stack[k] <= '0;
            end
            r_pending   <= 1'b0;
            r_itr_id    <= '0;
            r_pc        <= '0;
            r_nest_err  <= 1'b0;
        end else begin
            r_in_q    <= itr_in;
            r_pend    <= w_pend_nxt;
            r_pending <= w_cand_vld & ~w_ack;
            if (mask_wr) begin
                r_mask <= mask_in;
            end
            if (mode_wr) begin
                r_mode <= mode_in;
            end
            if (w_cand_vld) begin
                r_itr_id <= w_cand;
                r_pc     <= w_vec;
            end
            // A return always wins over a simultaneous acknowledge.
            if (itr_ret) begin
                if (r_depth != 4'd0) begin
                    r_active_id <= r_stack[w_below];
                    r_depth     <= r_depth - 4'd1;
                end else begin
                    r_nest_err  <= 1'b1;
                end
            end else if (w_ack && (r_depth < c_max_depth)) begin
                r_stack[w_top] <= r_active_id;
                r_active_id    <= r_itr_id;
                r_depth        <= r_depth + 4'd1;
            end
        end
    end

    assign i_pending   = r_pending;
    assign itr_pc_addr = r_pc;
    assign itr_id      = r_itr_id;
    assign active_id   = (r_depth == 4'd0) ? c_idle : r_active_id;
    assign itr_reg     = r_pend;
    assign mask_reg    = r_mask;
    assign depth       = r_depth;
    assign nest_err    = r_nest_err;

endmodule
`default_nettype wire

// File: tb/tb_vec_itr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec_itr_ctrl
// Brief    : Self-checking bench for vec_itr_ctrl against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_vec_itr_ctrl;

    localparam int        N    = 4;
    localparam int        ND   = 2;
    localparam int        STR  = 2;
    localparam logic [7:0] BASE = 8'hF0;

    logic         g_clk = 1'b0;
    logic         g_clr;
    logic [N-1:0] itr_in, mask_in, mode_in;
    logic         itr_en, mask_wr, mode_wr, itr_ack, itr_ret;
    logic         i_pending, nest_err;
    logic [7:0]   itr_pc_addr;
    logic [3:0]   itr_id, active_id, depth;
    logic [N-1:0] itr_reg, mask_reg;

    int total = 0;
    int bad   = 0;

    vec_itr_ctrl #(
        .N_SRC(N), .VEC_W(8), .VEC_BASE(BASE), .VEC_STRIDE(STR), .NEST_DEPTH(ND)
    ) dut (
        .g_clk(g_clk), .g_clr(g_clr), .itr_in(itr_in), .itr_en(itr_en),
        .mask_wr(mask_wr), .mask_in(mask_in), .mode_wr(mode_wr), .mode_in(mode_in),
        .itr_ack(itr_ack), .itr_ret(itr_ret), .i_pending(i_pending),
        .itr_pc_addr(itr_pc_addr), .itr_id(itr_id), .active_id(active_id),
        .itr_reg(itr_reg), .mask_reg(mask_reg), .depth(depth), .nest_err(nest_err)
    );

    always #5 g_clk = ~g_clk;

    // Reference model: interrupted contexts kept as a plain queue of ids.
    bit [N-1:0] m_inq, m_pend, m_mask, m_mode;
    int         m_stack[$];
    int         m_active;
    bit         m_pending;
    int         m_id;
    logic [7:0] m_vec;
    bit         m_err;

    task automatic model_reset();
        m_inq = '0; m_pend = '0; m_mask = '0; m_mode = '1;
        m_stack.delete();
        m_active = N; m_pending = 0; m_id = 0; m_vec = 8'h00; m_err = 0;
    endtask

    function automatic bit in_service(int i);
        foreach (m_stack[k]) if (m_stack[k] == i) return 1'b1;
        return 1'b0;
    endfunction

    // Advance model and DUT by one rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        bit         ack;
        int         cand;
        bit [N-1:0] np;
        ack  = itr_ack && m_pending && !itr_ret;
        cand = -1;
        if (itr_en && m_stack.size() < ND) begin
            for (int i = 0; i < N; i++) begin
                if (m_pend[i] && m_mask[i] && i < m_active && !in_service(i)) begin
                    cand = i;
                    break;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (m_mode[i]) begin
                np[i] = m_pend[i];
                if (ack && m_id == i) np[i] = 1'b0;
                if (itr_in[i] && !m_inq[i]) np[i] = 1'b1;
            end else begin
                np[i] = (mode_wr && mode_in[i]) ? 1'b0 : itr_in[i];
            end
        end
        if (itr_ret) begin
            if (m_stack.size() > 0) m_active = m_stack.pop_back();
            else m_err = 1'b1;
        end else if (ack) begin
            m_stack.push_back(m_active);
            m_active = m_id;
        end
        m_pend    = np;
        m_inq     = itr_in;
        m_pending = (cand >= 0) && !ack;
        if (cand >= 0) begin
            m_id  = cand;
            m_vec = 8'(int'(BASE) + cand * STR);
        end
        if (mask_wr) m_mask = mask_in;
        if (mode_wr) m_mode = mode_in;
        @(posedge g_clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge g_clk);
        g_clr = 1'b0;
        itr_in = '0; itr_en = 1'b0; mask_wr = 1'b0; mask_in = '0;
        mode_wr = 1'b0; mode_in = '0; itr_ack = 1'b0; itr_ret = 1'b0;
        @(negedge g_clk);
        g_clr = 1'b1;
        model_reset();
    endtask

    task automatic pulse(int src);
        itr_in[src] = 1'b1;
        tick();
        itr_in[src] = 1'b0;
    endtask

    task automatic strobe_ack();
        itr_ack = 1'b1; tick(); itr_ack = 1'b0;
    endtask

    task automatic strobe_ret();
        itr_ret = 1'b1; tick(); itr_ret = 1'b0;
    endtask

    task automatic enable_all();
        itr_en = 1'b1; mask_in = 4'hF; mask_wr = 1'b1;
        tick();
        mask_wr = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        total++; if (i_pending !== 1'b0 || itr_pc_addr !== 8'h00 || itr_id !== 4'd0) begin
            bad++; $display("FAIL reset_offer got pend=%b pc=%h id=%0d exp 0/00/0", i_pending, itr_pc_addr, itr_id);
        end
        total++; if (active_id !== 4'd4 || depth !== 4'd0 || nest_err !== 1'b0) begin
            bad++; $display("FAIL reset_service got act=%0d depth=%0d err=%b exp 4/0/0", active_id, depth, nest_err);
        end
        total++; if (itr_reg !== 4'h0 || mask_reg !== 4'h0) begin
            bad++; $display("FAIL reset_regs got pend=%b mask=%b exp 0000/0000", itr_reg, mask_reg);
        end
        @(negedge g_clk);
        g_clr = 1'b1;
        model_reset();
    endtask

    task automatic test_nested();
        apply_reset();
        enable_all();
        itr_in[2] = 1'b1; tick(); itr_in[2] = 1'b0;
        total++; if (itr_reg[2] !== 1'b1 || i_pending !== 1'b0) begin
            bad++; $display("FAIL nest_edge_k got pend2=%b ipend=%b exp 1/0", itr_reg[2], i_pending);
        end
        tick();
        total++; if (i_pending !== 1'b1 || itr_pc_addr !== 8'hF4 || itr_id !== 4'd2) begin
            bad++; $display("FAIL nest_offer2 got pend=%b pc=%h id=%0d exp 1/f4/2", i_pending, itr_pc_addr, itr_id);
        end
        strobe_ack();
        total++; if (i_pending !== 1'b0 || depth !== 4'd1 || active_id !== 4'd2) begin
            bad++; $display("FAIL nest_ack2 got pend=%b depth=%0d act=%0d exp 0/1/2", i_pending, depth, active_id);
        end
        pulse(0); tick();
        total++; if (i_pending !== 1'b1 || itr_pc_addr !== 8'hF0) begin
            bad++; $display("FAIL nest_offer0 got pend=%b pc=%h exp 1/f0", i_pending, itr_pc_addr);
        end
        strobe_ack();
        total++; if (depth !== 4'd2 || active_id !== 4'd0) begin
            bad++; $display("FAIL nest_ack0 got depth=%0d act=%0d exp 2/0", depth, active_id);
        end
        pulse(1); tick(); tick();
        total++; if (i_pending !== 1'b0 || itr_reg[1] !== 1'b1) begin
            bad++; $display("FAIL nest_full_block got ipend=%b pend1=%b exp 0/1", i_pending, itr_reg[1]);
        end
        strobe_ret();
        total++; if (active_id !== 4'd2 || depth !== 4'd1) begin
            bad++; $display("FAIL nest_ret1 got act=%0d depth=%0d exp 2/1", active_id, depth);
        end
        strobe_ret();
        total++; if (active_id !== 4'd4 || depth !== 4'd0) begin
            bad++; $display("FAIL nest_ret2 got act=%0d depth=%0d exp 4/0", active_id, depth);
        end
        tick();
        total++; if (i_pending !== 1'b1 || itr_pc_addr !== 8'hF2 || itr_id !== 4'd1) begin
            bad++; $display("FAIL nest_offer1 got pend=%b pc=%h id=%0d exp 1/f2/1", i_pending, itr_pc_addr, itr_id);
        end
    endtask

    task automatic test_level();
        apply_reset();
        itr_en = 1'b1;
        mode_in = 4'b0111; mode_wr = 1'b1; mask_in = 4'b1000; mask_wr = 1'b1;
        tick();
        mode_wr = 1'b0; mask_wr = 1'b0;
        itr_in[3] = 1'b1;
        tick();
        total++; if (itr_reg[3] !== 1'b1) begin
            bad++; $display("FAIL lvl_pend got %b exp 1", itr_reg[3]);
        end
        tick();
        total++; if (i_pending !== 1'b1 || itr_pc_addr !== 8'hF6) begin
            bad++; $display("FAIL lvl_offer got pend=%b pc=%h exp 1/f6", i_pending, itr_pc_addr);
        end
        strobe_ack(); tick();
        total++; if (i_pending !== 1'b0 || active_id !== 4'd3 || itr_reg[3] !== 1'b1) begin
            bad++; $display("FAIL lvl_service got ipend=%b act=%0d pend3=%b exp 0/3/1", i_pending, active_id, itr_reg[3]);
        end
        strobe_ret();
        total++; if (i_pending !== 1'b0 || depth !== 4'd0) begin
            bad++; $display("FAIL lvl_ret got ipend=%b depth=%0d exp 0/0", i_pending, depth);
        end
        tick();
        total++; if (i_pending !== 1'b1) begin
            bad++; $display("FAIL lvl_reoffer got %b exp 1", i_pending);
        end
        itr_in[3] = 1'b0;
        tick();
        total++; if (i_pending !== 1'b1 || itr_reg[3] !== 1'b0) begin
            bad++; $display("FAIL lvl_drop1 got ipend=%b pend3=%b exp 1/0", i_pending, itr_reg[3]);
        end
        tick();
        total++; if (i_pending !== 1'b0) begin
            bad++; $display("FAIL lvl_drop2 got %b exp 0", i_pending);
        end
    endtask

    task automatic test_mask();
        apply_reset();
        itr_en = 1'b1;
        pulse(1); tick(); tick();
        total++; if (itr_reg[1] !== 1'b1 || i_pending !== 1'b0) begin
            bad++; $display("FAIL mask_hold got pend1=%b ipend=%b exp 1/0", itr_reg[1], i_pending);
        end
        mask_in = 4'b0010; mask_wr = 1'b1;
        tick();
        mask_wr = 1'b0;
        total++; if (i_pending !== 1'b0 || mask_reg !== 4'b0010) begin
            bad++; $display("FAIL mask_write got ipend=%b mask=%b exp 0/0010", i_pending, mask_reg);
        end
        tick();
        total++; if (i_pending !== 1'b1 || itr_pc_addr !== 8'hF2) begin
            bad++; $display("FAIL mask_offer got pend=%b pc=%h exp 1/f2", i_pending, itr_pc_addr);
        end
    endtask

    task automatic test_ack_ret_err();
        apply_reset();
        enable_all();
        pulse(2); tick();
        strobe_ack();
        pulse(0); tick();
        itr_ack = 1'b1; itr_ret = 1'b1;
        tick();
        itr_ack = 1'b0; itr_ret = 1'b0;
        total++; if (depth !== 4'd0 || active_id !== 4'd4 || itr_reg[0] !== 1'b1 || nest_err !== 1'b0) begin
            bad++; $display("FAIL ackret got depth=%0d act=%0d pend0=%b err=%b exp 0/4/1/0", depth, active_id, itr_reg[0], nest_err);
        end
        strobe_ret();
        total++; if (nest_err !== 1'b1 || depth !== 4'd0) begin
            bad++; $display("FAIL nest_err_set got err=%b depth=%0d exp 1/0", nest_err, depth);
        end
        tick(); tick();
        total++; if (nest_err !== 1'b1) begin
            bad++; $display("FAIL nest_err_sticky got %b exp 1", nest_err);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        enable_all();
        pulse(2); tick(); strobe_ack();
        pulse(0); tick(); strobe_ack();
        total++; if (depth !== 4'd2) begin
            bad++; $display("FAIL arst_setup got depth=%0d exp 2", depth);
        end
        #2;
        g_clr = 1'b0;
        #1;
        total++; if (depth !== 4'd0 || active_id !== 4'd4 || i_pending !== 1'b0 || itr_pc_addr !== 8'h00 ||
                     itr_id !== 4'd0 || itr_reg !== 4'h0 || mask_reg !== 4'h0 || nest_err !== 1'b0) begin
            bad++; $display("FAIL arst_clear got depth=%0d act=%0d pend=%b pc=%h id=%0d preg=%b mask=%b err=%b exp all reset",
                            depth, active_id, i_pending, itr_pc_addr, itr_id, itr_reg, mask_reg, nest_err);
        end
        @(negedge g_clk);
        g_clr = 1'b1;
        model_reset();
        itr_in = '0; itr_en = 1'b0;
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 500; c++) begin
            itr_in  = itr_in ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            itr_en  = ($urandom_range(0, 9) != 0);
            mask_wr = ($urandom_range(0, 15) == 0);
            mask_in = 4'($urandom_range(0, 15));
            mode_wr = ($urandom_range(0, 19) == 0);
            mode_in = 4'($urandom_range(0, 15));
            itr_ack = ($urandom_range(0, 2) == 0);
            itr_ret = ($urandom_range(0, 6) == 0);
            tick();
            total++; if (i_pending !== m_pending) begin
                bad++; $display("FAIL rnd_pending cyc=%0d got %b exp %b", c, i_pending, m_pending);
            end
            total++; if (itr_id !== 4'(m_id) || itr_pc_addr !== m_vec) begin
                bad++; $display("FAIL rnd_vector cyc=%0d got id=%0d pc=%h exp id=%0d pc=%h", c, itr_id, itr_pc_addr, m_id, m_vec);
            end
            total++; if (active_id !== 4'(m_active) || depth !== 4'(m_stack.size())) begin
                bad++; $display("FAIL rnd_service cyc=%0d got act=%0d depth=%0d exp act=%0d depth=%0d",
                                c, active_id, depth, m_active, m_stack.size());
            end
            total++; if (itr_reg !== m_pend || mask_reg !== m_mask || nest_err !== m_err) begin
                bad++; $display("FAIL rnd_regs cyc=%0d got pend=%b mask=%b err=%b exp pend=%b mask=%b err=%b",
                                c, itr_reg, mask_reg, nest_err, m_pend, m_mask, m_err);
            end
        end
        itr_ack = 1'b0; itr_ret = 1'b0; mask_wr = 1'b0; mode_wr = 1'b0;
    endtask

    initial begin
        g_clr = 1'b0;
        itr_in = '0; itr_en = 1'b0; mask_wr = 1'b0; mask_in = '0;
        mode_wr = 1'b0; mode_in = '0; itr_ack = 1'b0; itr_ret = 1'b0;
        model_reset();
        test_reset();
        test_nested();
        test_level();
        test_mask();
        test_ack_ret_err();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
